branch_predictor_table: RTL

Parametrised branch-direction predictor: a table of 2^INDEX_BITS saturating counters, indexed by the word-aligned PC. The index is optionally hashed with a global history register (gshare). It is a fetch-side lookup port with a registered prediction, plus a resolve-side update port driven by the execute stage. Counters and history are clocked storage with reset. A mispredict statistics counter is included for performance analysis.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_sat_ctr.sv | 26 ++
 rtl/branch_predictor_table.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor table.
//   PC_IDX_LSB  : lowest PC bit used for the table index (word-aligned PCs)
//   STAT_W      : width of the performance statistics counters
//   ctr_init()  : reset value of a CTR_BITS-wide counter ("weakly taken",
//                 MSB set, all other bits clear)
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int PC_IDX_LSB = 2;
  localparam int STAT_W     = 32;

  function automatic int unsigned ctr_init(input int unsigned ctr_bits);
    return 32'd1 << (ctr_bits - 1);
  endfunction

endpackage : bp_pkg

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr
// Combinational next-state of one saturating direction counter.
//   value      in  CTR_BITS  current counter value
//   taken      in  1         resolved outcome (1 = count up, 0 = count down)
//   next_value out CTR_BITS  updated value, clamped to [0, 2^CTR_BITS-1]
// ---------------------------------------------------------------------------
module bp_sat_ctr #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next_value
);

  always_comb begin
    // NOTE: default first so every path assigns next_value and no latch is inferred.
    next_value = value;
    if (taken) begin
      if (value != '1) next_value = value + 1'b1;
    end else begin
      if (value != '0) next_value = value - 1'b1;
    end
  end

endmodule : bp_sat_ctr

// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// branch_predictor_table
// Table of 2^INDEX_BITS saturating direction counters with a registered
// fetch-side lookup and an execute-side update port.
//
// Build option: define BP_GSHARE_EN to XOR a non-speculative global history
// register into the lookup index (gshare). Without it the predictor is pure
// bimodal and no history flops exist.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   lookup_valid    fetch requests a prediction this cycle
//   lookup_pc       PC of the fetched branch
//   pred_valid      registered, high one cycle after lookup_valid
//   pred_taken      registered prediction (counter MSB)
//   pred_index      registered table index, carried down the pipe to resolve
//   upd_valid       branch resolved this cycle
//   upd_index       index previously returned on pred_index
//   upd_taken       actual outcome
//   upd_pred        prediction that was made for this branch
//   mispredict_cnt  saturating count of updates with upd_taken != upd_pred
// ---------------------------------------------------------------------------
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_pred,
  output logic [STAT_W-1:0]     mispredict_cnt
);

  localparam int                DEPTH   = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_init(CTR_BITS));

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [CTR_BITS-1:0]   ctr_next;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  unused_pc_bits;

  assign pc_idx = lookup_pc[PC_IDX_LSB +: INDEX_BITS];

  // Only the index field of the PC matters; the rest is deliberately ignored.
  assign unused_pc_bits = ^{lookup_pc[31:PC_IDX_LSB+INDEX_BITS],
                            lookup_pc[PC_IDX_LSB-1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q;

  // Lookup always hashes with the pre-shift history, even when an update
  // resolves on the same edge.
  assign lookup_idx = pc_idx ^ INDEX_BITS'(ghr_q);

  // History advances only on resolved branches (non-speculative). The cast
  // drops the oldest bit out of the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= HIST_BITS'({ghr_q, upd_taken});
    end
  end
`else
  assign lookup_idx = pc_idx;
`endif

  // Single next-state calculator shared by all entries: only one counter
  // (the one at upd_index) can change per cycle.
  bp_sat_ctr #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_ctr (
    .value      (table_q[upd_index]),
    .taken      (upd_taken),
    .next_value (ctr_next)
  );

  // Counter table: flops rather than RAM so every entry can be initialised
  // to weakly-taken by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose; a RAM macro could not do this,
      // so the table must stay as flops for the reset value to be defined.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_RST;
    end else if (upd_valid) begin
      // NOTE: non-blocking, so a lookup on the same edge still sees the
      // pre-update counter (no bypass).
      table_q[upd_index] <= ctr_next;
    end
  end

  // Registered prediction. Index and direction hold when no lookup arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_index <= lookup_idx;
        pred_taken <= table_q[lookup_idx][CTR_BITS-1];
      end
    end
  end

  // Mispredict statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && (upd_taken != upd_pred) && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule : branch_predictor_table
